ahbl_sram_responder: RTL and testbench

AHB-Lite subordinate with an internal word-addressed memory, programmable fixed wait states and two-cycle ERROR responses. It is the responding end of the CPU's instruction and data manager ports, and it replaces the free-running random bus in directed simulation and bounded formal runs. It gives the core a deterministic, protocol-correct memory to fetch from and load from or store to.

---
 rtl/ahbl_pkg.sv | 39 +++
 rtl/ahbl_sram_array.sv | 33 +++
 rtl/ahbl_sram_responder.sv | 155 +++++++++++++++
 tb/tb_ahbl_sram_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite definitions for the SRAM responder.
//   - HTRANS / HSIZE encodings
//   - responder state enum
//   - byte_strobe(): size + lane offset -> per-byte write strobe (up to 8 lanes)
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Lane offset must already be reduced to the bus width; the caller
    // truncates the result to W_DATA/8 bits.
    function automatic logic [7:0] byte_strobe(input logic [2:0] hsize,
                                               input logic [2:0] lane);
        logic [7:0] base;
        case (hsize)
            HSIZE_BYTE:  base = 8'h01;
            HSIZE_HALF:  base = 8'h03;
            HSIZE_WORD:  base = 8'h0F;
            HSIZE_DWORD: base = 8'hFF;
            default:     base = '0;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/ahbl_sram_array.sv
// ahbl_sram_array: DEPTH x W_DATA storage, per-byte write strobe,
// asynchronous read port. Contents are not reset.
//   clock    in   write clock
//   wr_strb  in   per-byte write enable (W_DATA/8)
//   wr_idx   in   write word index
//   wr_data  in   write data
//   rd_idx   in   read word index
//   rd_data  out  read data (combinational)
module ahbl_sram_array #(
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                     clock,
    input  logic [W_DATA/8-1:0]      wr_strb,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [W_DATA-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [W_DATA-1:0]        rd_data
);

    logic [W_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int unsigned b = 0; b < W_DATA/8; b++) begin
            if (wr_strb[b]) begin
                mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ahbl_sram_responder.sv
// ahbl_sram_responder: AHB-Lite subordinate backed by an internal SRAM,
// with fixed programmable wait states and two-cycle ERROR responses.
//   clock, reset           clock, async active-high reset
//   ahbls_hready           bus HREADY (previous transfer done)
//   ahbls_hready_resp      HREADYOUT
//   ahbls_hresp            0 = OKAY, 1 = ERROR
//   ahbls_haddr/hwrite/htrans/hsize   address-phase controls
//   ahbls_hburst/hprot/hmastlock      accepted but ignored
//   ahbls_hwdata           write data (data phase)
//   ahbls_hrdata           read data, zero outside good read data phases
module ahbl_sram_responder
    import ahbl_pkg::*;
#(
    parameter int unsigned W_ADDR      = 32,
    parameter int unsigned W_DATA      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int unsigned     BYTES    = W_DATA / 8;
    localparam int unsigned     ADDR_LSB = $clog2(BYTES);
    localparam int unsigned     IDX_W    = $clog2(DEPTH);
    localparam longint unsigned LIMIT    = longint'(DEPTH) * longint'(BYTES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       lo_q, lo_d;
    logic [2:0]       size_q, size_d;
    logic             write_q, write_d;
    logic             dphase_q, dphase_d;       // good transfer in data phase
    logic             hready_resp_q, hready_resp_d;
    logic             hresp_q, hresp_d;

    logic             accept;
    logic             addr_err;
    logic             done;
    logic [6:0]       align_mask;
    logic [7:0]       strobe_full;
    logic [BYTES-1:0] wr_strb;
    logic [W_DATA-1:0] mem_rdata;

    always_comb begin
        accept      = ahbls_hready && ahbls_htrans[1];
        align_mask  = 7'((8'd1 << ahbls_hsize) - 8'd1);
        addr_err    = (64'(ahbls_haddr) >= LIMIT)
                   || (ahbls_hsize > 3'(ADDR_LSB))
                   || ((ahbls_haddr[6:0] & align_mask) != '0);
        done        = dphase_q && hready_resp_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        size_d   = size_q;
        write_d  = write_q;
        dphase_d = dphase_q && !done;

        unique case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Completing cycle is spent back in IDLE with HREADYOUT high.
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                // IDLE and ERR2 both drive HREADYOUT high, so both accept.
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d   = ahbls_haddr[ADDR_LSB +: IDX_W];
                    lo_d    = ahbls_haddr[2:0] & 3'(BYTES - 1);
                    size_d  = ahbls_hsize;
                    write_d = ahbls_hwrite;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        dphase_d = 1'b1;
                        if (WAIT_CYCLES != 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = 4'(WAIT_CYCLES);
                        end
                    end
                end
            end
        endcase

        hready_resp_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
        hresp_d       = (state_d == ST_ERR1) || (state_d == ST_ERR2);

        strobe_full = byte_strobe(size_q, lo_q);
        wr_strb     = (dphase_q && write_q && hready_resp_q) ? strobe_full[BYTES-1:0] : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            lo_q          <= '0;
            size_q        <= '0;
            write_q       <= 1'b0;
            dphase_q      <= 1'b0;
            hready_resp_q <= 1'b1;
            hresp_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            lo_q          <= lo_d;
            size_q        <= size_d;
            write_q       <= write_d;
            dphase_q      <= dphase_d;
            hready_resp_q <= hready_resp_d;
            hresp_q       <= hresp_d;
        end
    end

    ahbl_sram_array #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock   (clock),
        .wr_strb (wr_strb),
        .wr_idx  (idx_q),
        .wr_data (ahbls_hwdata),
        .rd_idx  (idx_q),
        .rd_data (mem_rdata)
    );

    assign ahbls_hready_resp = hready_resp_q;
    assign ahbls_hresp       = hresp_q;
    assign ahbls_hrdata      = (dphase_q && !write_q) ? mem_rdata : '0;

    logic unused_inputs;
    assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                             ahbls_htrans[0], strobe_full};

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Bench for ahbl_sram_responder: two instances (WAIT_CYCLES 0 and 3) share
// one stimulus bus selected by 'sel'; a transaction-level memory model
// predicts every data-phase cycle.
module tb_ahbl_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [1:0]  htrans, htrans0, htrans1;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        rdy0, rdy1, resp0, resp1;
    logic [31:0] rd0, rd1;
    logic        bus_rdy, bus_resp;
    logic [31:0] bus_rdata;

    always #5 clock = ~clock;

    assign htrans0   = sel ? 2'b00 : htrans;
    assign htrans1   = sel ? htrans : 2'b00;
    assign bus_rdy   = sel ? rdy1 : rdy0;
    assign bus_resp  = sel ? resp1 : resp0;
    assign bus_rdata = sel ? rd1 : rd0;

    ahbl_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset), .ahbls_hready(rdy0), .ahbls_hready_resp(rdy0),
        .ahbls_hresp(resp0), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans0), .ahbls_hsize(hsize), .ahbls_hburst(hburst),
        .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock), .ahbls_hwdata(hwdata),
        .ahbls_hrdata(rd0)
    );

    ahbl_sram_responder #(.W_ADDR(32), .W_DATA(32), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clock(clock), .reset(reset), .ahbls_hready(rdy1), .ahbls_hready_resp(rdy1),
        .ahbls_hresp(resp1), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite),
        .ahbls_htrans(htrans1), .ahbls_hsize(hsize), .ahbls_hburst(hburst),
        .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock), .ahbls_hwdata(hwdata),
        .ahbls_hrdata(rd1)
    );

    typedef struct {
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    vec_t        tbl [16];
    vec_t        seq_q [$];
    bit          obs_err [];
    int          obs_lows [];
    logic [31:0] obs_rdata [];

    logic [31:0] mdl   [2][1024];
    bit          known [2][1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
        int unsigned n;
        n = 32'd1 << sz;
        return (a >= 32'd4096) || (sz > 3'd2) || ((a % n) != 0);
    endfunction

    task automatic model_write(input int s, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd);
        logic [9:0]  idx;
        logic [31:0] w;
        int          lane;
        idx = a[11:2];
        w   = mdl[s][idx];
        for (int b = 0; b < (1 << sz); b++) begin
            lane = int'(a % 4) + b;
            w[lane*8 +: 8] = wd[lane*8 +: 8];
        end
        mdl[s][idx] = w;
        if (sz == 3'd2) known[s][idx] = 1'b1;
    endtask

    // Runs seq_q back-to-back; entered and left just after a rising edge.
    task automatic run_seq();
        int          ai, dp, k, cyc, w, s;
        logic        rdy, exp_rdy, exp_resp;
        logic [31:0] exp_rd, a;
        bit          dp_err, dp_good, rd_known;
        s = sel ? 1 : 0;
        w = sel ? 3 : 0;
        ai = 0; dp = -1; k = 0; cyc = 0;
        obs_err   = new[seq_q.size()];
        obs_lows  = new[seq_q.size()];
        obs_rdata = new[seq_q.size()];
        foreach (obs_err[i]) begin
            obs_err[i] = 0; obs_lows[i] = 0; obs_rdata[i] = '0;
        end
        while ((ai < seq_q.size() || dp >= 0) && cyc < 4000) begin
            if (ai < seq_q.size()) begin
                htrans = seq_q[ai].trans; haddr = seq_q[ai].addr;
                hwrite = seq_q[ai].write; hsize = seq_q[ai].size;
            end else begin
                htrans = 2'b00;
            end
            hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
            hwdata = (dp >= 0) ? seq_q[dp].wdata : $urandom;
            @(negedge clock);
            exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = '0;
            dp_err = 0; dp_good = 0; rd_known = 1;
            if (dp >= 0) begin
                a       = seq_q[dp].addr;
                dp_err  = seq_q[dp].trans[1] && is_err(a, seq_q[dp].size);
                dp_good = seq_q[dp].trans[1] && !dp_err;
                if (dp_err) begin
                    exp_rdy  = (k != 0);
                    exp_resp = 1'b1;
                end else if (dp_good) begin
                    exp_rdy = (k == w);
                    if (!seq_q[dp].write) begin
                        exp_rd   = mdl[s][a[11:2]];
                        rd_known = known[s][a[11:2]];
                    end
                end
            end
            chk($sformatf("hready_resp s=%0d item=%0d k=%0d", s, dp, k), 32'(bus_rdy), 32'(exp_rdy));
            chk($sformatf("hresp s=%0d item=%0d k=%0d", s, dp, k), 32'(bus_resp), 32'(exp_resp));
            if (rd_known)
                chk($sformatf("hrdata s=%0d item=%0d k=%0d", s, dp, k), bus_rdata, exp_rd);
            if (dp >= 0) begin
                if (bus_resp) obs_err[dp] = 1;
                if (!bus_rdy) obs_lows[dp]++;
                obs_rdata[dp] = bus_rdata;
            end
            rdy = bus_rdy;
            @(posedge clock);
            if (rdy) begin
                if (dp_good && seq_q[dp].write)
                    model_write(s, seq_q[dp].addr, seq_q[dp].size, seq_q[dp].wdata);
                if (ai < seq_q.size()) begin
                    dp = ai; ai++;
                end else begin
                    dp = -1;
                end
                k = 0;
            end else begin
                k++;
            end
            #1;
            cyc++;
        end
        htrans = 2'b00;
        chk("seq_completes_in_budget", 32'(cyc < 4000), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [31:0] lo;
        int          exp_lows;

        // trans, write, size, addr, wdata, exp_err, exp_rdata
        tbl[0]  = '{2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{2'b10, 1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{2'b10, 1'b1, 3'd0, 32'h0000_0013, 32'h5A00_0000, 1'b0, 32'h0};
        tbl[3]  = '{2'b11, 1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'h5AAD_BEEF};
        tbl[4]  = '{2'b10, 1'b0, 3'd2, 32'h0000_1000, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{2'b10, 1'b1, 3'd1, 32'h0000_0011, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[6]  = '{2'b10, 1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'h5AAD_BEEF};
        tbl[7]  = '{2'b00, 1'b1, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'h0};
        tbl[8]  = '{2'b01, 1'b1, 3'd0, 32'h0000_0010, 32'h0,         1'b0, 32'h0};
        tbl[9]  = '{2'b10, 1'b0, 3'd3, 32'h0000_0010, 32'h0,         1'b1, 32'h0};
        tbl[10] = '{2'b10, 1'b0, 3'd2, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{2'b10, 1'b1, 3'd1, 32'h0000_0012, 32'h1234_0000, 1'b0, 32'h0};
        tbl[12] = '{2'b10, 1'b0, 3'd0, 32'h0000_0011, 32'h0,         1'b0, 32'h1234_BEEF};
        tbl[13] = '{2'b10, 1'b1, 3'd2, 32'h0000_0FFC, 32'h0102_0304, 1'b0, 32'h0};
        tbl[14] = '{2'b10, 1'b0, 3'd2, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0102_0304};
        tbl[15] = '{2'b10, 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

        foreach (known[s, i]) known[s][i] = 1'b0;

        sel = 1'b0; reset = 1'b1;
        htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = '0; hwdata = '0;
        hburst = '0; hprot = '0; hmastlock = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_hready_resp0", 32'(rdy0), 32'd1);
        chk("reset_hresp0", 32'(resp0), 32'd0);
        chk("reset_hrdata0", rd0, 32'd0);
        chk("reset_hready_resp3", 32'(rdy1), 32'd1);
        chk("reset_hresp3", 32'(resp1), 32'd0);
        chk("reset_hrdata3", rd1, 32'd0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;

        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);

            seq_q.delete();
            foreach (tbl[i]) seq_q.push_back(tbl[i]);
            run_seq();
            foreach (tbl[i]) begin
                exp_lows = !tbl[i].trans[1] ? 0 : (tbl[i].exp_err ? 1 : (s == 1 ? 3 : 0));
                chk($sformatf("tbl_err s=%0d i=%0d", s, i), 32'(obs_err[i]), 32'(tbl[i].exp_err));
                chk($sformatf("tbl_wait s=%0d i=%0d", s, i), 32'(obs_lows[i]), 32'(exp_lows));
                chk($sformatf("tbl_rdata s=%0d i=%0d", s, i), obs_rdata[i], tbl[i].exp_rdata);
            end

            seq_q.delete();
            for (int i = 0; i < 16; i++) begin
                v = '{2'b10, 1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0, 32'h0};
                seq_q.push_back(v);
            end
            run_seq();

            seq_q.delete();
            for (int i = 0; i < 200; i++) begin
                case ($urandom_range(0, 7))
                    0:       v.trans = 2'b00;
                    1:       v.trans = 2'b01;
                    2:       v.trans = 2'b11;
                    default: v.trans = 2'b10;
                endcase
                v.write = 1'($urandom);
                v.size  = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(3, 7))
                                                     : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) begin
                    lo = 32'($urandom_range(0, 3));
                end else begin
                    lo = 32'($urandom_range(0, 3)) & ~((32'd1 << v.size) - 32'd1);
                    lo = lo & 32'd3;
                end
                v.addr  = ($urandom_range(0, 15) == 0) ? (32'h1000 | ($urandom & 32'hFFFF))
                                                       : (32'($urandom_range(0, 15)) << 2) | lo;
                v.wdata = $urandom;
                v.exp_err = 1'b0; v.exp_rdata = '0;
                seq_q.push_back(v);
            end
            run_seq();
        end

        // Reset during the wait states of a write aborts it.
        sel = 1'b1;
        seq_q.delete();
        seq_q.push_back('{2'b10, 1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0});
        run_seq();
        htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clock); #1;
        htrans = 2'b00; hwdata = 32'h1111_1111;
        @(negedge clock);
        chk("rst_mid_wait_low", 32'(bus_rdy), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_hready_resp", 32'(bus_rdy), 32'd1);
        chk("rst_async_hresp", 32'(bus_resp), 32'd0);
        chk("rst_async_hrdata", bus_rdata, 32'd0);
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;
        seq_q.delete();
        seq_q.push_back('{2'b10, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h0});
        run_seq();
        chk("rst_mem_unchanged", obs_rdata[0], 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
